axil_reg_bank: RTL

- Parametrised AXI4-Lite slave register bank. Successor to the fixed 4 x 32-bit example slave IP.
- Adds configurable register count and data width, byte strobes, and per-register read-only status inputs.
- Rejects bad accesses with SLVERR.
- Sits behind the AXI interconnect in the block design and exposes control outputs and status inputs to user logic.

---
 rtl/axil_reg_bank_pkg.sv | 18 +
 rtl/axil_reg_bank_wstrb_merge.sv | 23 ++
 rtl/axil_reg_bank.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_bank_pkg.sv
// Shared definitions for the axil_reg_bank AXI4-Lite register bank:
// response codes, write-path state type and the byte-address offset helper.
package axil_reg_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    function automatic int addrLsb(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/axil_reg_bank_wstrb_merge.sv
// Byte-lane merge for axil_reg_bank: lanes with a set strobe take the new
// data, all other lanes keep the old data.
module axil_reg_bank_wstrb_merge
    import axil_reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_i,
    input  logic [DATA_WIDTH-1:0]   new_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic [DATA_WIDTH-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (strb_i[b]) begin
                merged_o[b*8 +: 8] = new_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_reg_bank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only
// status registers and SLVERR on bad accesses. Optional sticky interrupt
// status/enable pair in the top two registers when AXIL_REG_BANK_IRQ_EN is defined.
module axil_reg_bank
    import axil_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
`ifdef AXIL_REG_BANK_IRQ_EN
    input  logic [DATA_WIDTH-1:0]          irq_in,
    output logic                           irq,
`endif
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int ADDR_LSB = addrLsb(DATA_WIDTH);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int FULL_W   = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;
`ifdef AXIL_REG_BANK_IRQ_EN
    localparam int IRQ_STAT = NUM_REGS - 1;
    localparam int IRQ_ENA  = NUM_REGS - 2;
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~(NUM_REGS'(3) << (NUM_REGS - 2));
`else
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    wr_state_t             wrState_q, wrState_d, wrPhase;
    logic                  rdyEn_q;
    logic                  awHeld_q, wHeld_q;
    logic [ADDR_WIDTH-1:0] awAddr_q;
    logic [DATA_WIDTH-1:0] wData_q;
    logic [STRB_W-1:0]     wStrb_q;
    logic [1:0]            bResp_q;
    logic                  rValid_q;
    logic [DATA_WIDTH-1:0] rData_q;
    logic [1:0]            rResp_q;
    logic [NUM_REGS-1:0]   wrPulse_q;

    logic                  awFire, wFire, arFire, commit;
    logic [ADDR_WIDTH-1:0] wAddr;
    logic [DATA_WIDTH-1:0] wData, merged, rdSel;
    logic [STRB_W-1:0]     wStrb;
    logic [FULL_W-1:0]     wFullIdx, rFullIdx;
    logic [IDX_W-1:0]      wIdx, rIdx;
    logic                  wInRange, rInRange, wOk, wIsStat;
    logic                  unused_ok;

    assign S_AXI_AWREADY = rdyEn_q && (wrState_q == WR_IDLE) && !awHeld_q;
    assign S_AXI_WREADY  = rdyEn_q && (wrState_q == WR_IDLE) && !wHeld_q;
    assign S_AXI_ARREADY = rdyEn_q && !rValid_q;
    assign S_AXI_BVALID  = (wrState_q == WR_RESP);
    assign S_AXI_BRESP   = bResp_q;
    assign S_AXI_RVALID  = rValid_q;
    assign S_AXI_RDATA   = rData_q;
    assign S_AXI_RRESP   = rResp_q;
    assign wr_pulse      = wrPulse_q;

    assign awFire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign wFire  = S_AXI_WVALID && S_AXI_WREADY;
    assign arFire = S_AXI_ARVALID && S_AXI_ARREADY;

    // A side arriving this cycle is used directly so the commit lands on its handshake edge.
    assign wAddr    = awHeld_q ? awAddr_q : S_AXI_AWADDR;
    assign wData    = wHeld_q ? wData_q : S_AXI_WDATA;
    assign wStrb    = wHeld_q ? wStrb_q : S_AXI_WSTRB;
    assign wFullIdx = wAddr[ADDR_WIDTH-1:ADDR_LSB];
    assign wIdx     = wFullIdx[IDX_W-1:0];
    assign wInRange = (wFullIdx < FULL_W'(NUM_REGS));
    assign wOk      = wInRange && !RO_EFF[wIdx];
    assign rFullIdx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign rIdx     = rFullIdx[IDX_W-1:0];
    assign rInRange = (rFullIdx < FULL_W'(NUM_REGS));

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wAddr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    always_comb begin
        wrPhase   = wrState_q;
        wrState_d = wrState_q;
        if ((wrState_q == WR_IDLE) && (awHeld_q || awFire) && (wHeld_q || wFire)) begin
            wrPhase = WR_COMMIT;
        end
        case (wrPhase)
            WR_COMMIT: wrState_d = WR_RESP;
            WR_RESP:   if (S_AXI_BREADY) wrState_d = WR_IDLE;
            default:   wrState_d = WR_IDLE;
        endcase
    end

    assign commit = (wrPhase == WR_COMMIT);

    always_comb begin
        rdSel = '0;
        if (rInRange) begin
            rdSel = RO_EFF[rIdx] ? status_in[rIdx*DATA_WIDTH +: DATA_WIDTH] : regs_q[rIdx];
        end
    end

    axil_reg_bank_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .old_i   (regs_q[wIdx]),
        .new_i   (wData),
        .strb_i  (wStrb),
        .merged_o(merged)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdyEn_q   <= 1'b0;
            wrState_q <= WR_IDLE;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bResp_q   <= RESP_OKAY;
            rValid_q  <= 1'b0;
            rData_q   <= '0;
            rResp_q   <= RESP_OKAY;
            wrPulse_q <= '0;
        end else begin
            rdyEn_q   <= 1'b1;
            wrState_q <= wrState_d;
            wrPulse_q <= '0;
            if (commit) begin
                awHeld_q <= 1'b0;
                wHeld_q  <= 1'b0;
                bResp_q  <= wOk ? RESP_OKAY : RESP_SLVERR;
                if (wOk) begin
                    wrPulse_q[wIdx] <= 1'b1;
                end
            end else begin
                if (awFire) begin
                    awHeld_q <= 1'b1;
                    awAddr_q <= S_AXI_AWADDR;
                end
                if (wFire) begin
                    wHeld_q <= 1'b1;
                    wData_q <= S_AXI_WDATA;
                    wStrb_q <= S_AXI_WSTRB;
                end
            end
            if (arFire) begin
                rValid_q <= 1'b1;
                rData_q  <= rdSel;
                rResp_q  <= rInRange ? RESP_OKAY : RESP_SLVERR;
            end else if (rValid_q && S_AXI_RREADY) begin
                rValid_q <= 1'b0;
            end
        end
    end

`ifdef AXIL_REG_BANK_IRQ_EN
    logic [DATA_WIDTH-1:0] strobedData, clrMask;
    logic                  irq_q;

    axil_reg_bank_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_clr_merge (
        .old_i   ('0),
        .new_i   (wData),
        .strb_i  (wStrb),
        .merged_o(strobedData)
    );

    assign wIsStat = (wIdx == IDX_W'(IRQ_STAT));
    assign clrMask = (commit && wOk && wIsStat) ? strobedData : '0;
    assign irq     = irq_q;
`else
    assign wIsStat = 1'b0;
`endif

    // Interrupt status is written every cycle so a new irq_in bit beats a same-cycle clear.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
`ifdef AXIL_REG_BANK_IRQ_EN
            regs_q[IRQ_STAT] <= '0;
            irq_q            <= 1'b0;
`endif
        end else begin
            if (commit && wOk && !wIsStat) begin
                regs_q[wIdx] <= merged;
            end
`ifdef AXIL_REG_BANK_IRQ_EN
            regs_q[IRQ_STAT] <= (regs_q[IRQ_STAT] & ~clrMask) | irq_in;
            irq_q            <= |(regs_q[IRQ_STAT] & regs_q[IRQ_ENA]);
`endif
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gen_ctrl
        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule
